// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store engine:
// funct3 width codes, FSM state encoding, bus lane width and store helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Alignment check; unsigned widths have no store form, so they fault on stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off,
                                      input logic store);
    case (f3)
      F3_B:    misaligned = 1'b0;
      F3_BU:   misaligned = store;
      F3_H:    misaligned = off[0];
      F3_HU:   misaligned = store | off[0];
      F3_W:    misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Byte enables for a store of width f3 at lane offset off.
  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane so the byte enables pick the slot.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    store_wdata = {4{d[7:0]}};
      F3_H:    store_wdata = {2{d[15:0]}};
      F3_W:    store_wdata = d;
      default: store_wdata = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load extraction: picks the byte/halfword lane out of the
// read word and sign- or zero-extends it according to the funct3 width code.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection from the byte offset.
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_off[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Width-dependent extension of the selected lane.
  always_comb begin
    o_value = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_value = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_value = {{16{w_half[15]}}, w_half};
      F3_W:    o_value = i_rdata;
      F3_BU:   o_value = {24'h00_0000, w_byte};
      F3_HU:   o_value = {16'h0000, w_half};
      default: o_value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: accepts one operation from EX, runs a
// req/ack transaction on the data bus, and returns the extended load result
// (or an error for misalignment / bus timeout) to write-back.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] mem_data,
  output logic              out_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [BE_W-1:0]   dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [2:0]          r_funct3, w_funct3_nxt;
  logic [1:0]          r_off, w_off_nxt;
  logic                r_is_load, w_is_load_nxt;
  logic                r_req, w_req_nxt;
  logic                r_we, w_we_nxt;
  logic [DATA_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [BE_W-1:0]     r_be, w_be_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_out_err, w_out_err_nxt;
  logic [DATA_W-1:0]   r_mem_data, w_mem_data_nxt;
  logic [DATA_W-1:0]   w_ext;
  logic                w_store_op;

  // A load wins when both request flags are set.
  assign w_store_op = is_store & ~is_load;

  load_extend u_load_extend (
    .i_rdata  (dmem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_value  (w_ext)
  );

  // Next-state and next-output decode for the IDLE/REQ/DONE sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_funct3_nxt    = r_funct3;
    w_off_nxt       = r_off;
    w_is_load_nxt   = r_is_load;
    w_req_nxt       = r_req;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_be_nxt        = r_be;
    w_out_valid_nxt = 1'b0;
    w_out_err_nxt   = r_out_err;
    w_mem_data_nxt  = r_mem_data;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_load && !is_store) begin
            w_state_nxt     = ST_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_err_nxt   = 1'b0;
            w_mem_data_nxt  = 32'h0000_0000;
          end else if (misaligned(funct3, addr[1:0], w_store_op)) begin
            w_state_nxt     = ST_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_err_nxt   = 1'b1;
            w_mem_data_nxt  = 32'h0000_0000;
          end else begin
            w_state_nxt   = ST_REQ;
            w_cnt_nxt     = {CNT_W{1'b0}};
            w_funct3_nxt  = funct3;
            w_off_nxt     = addr[1:0];
            w_is_load_nxt = ~w_store_op;
            w_req_nxt     = 1'b1;
            w_we_nxt      = w_store_op;
            w_addr_nxt    = {addr[DATA_W-1:2], 2'b00};
            if (w_store_op) begin
              w_be_nxt    = store_be(funct3, addr[1:0]);
              w_wdata_nxt = store_wdata(funct3, store_data);
            end else begin
              w_be_nxt    = 4'b0000;
              w_wdata_nxt = 32'h0000_0000;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_ack || (r_cnt == CNT_W'(ACK_TIMEOUT - 1))) begin
          // Ack takes priority over a timeout landing on the same cycle.
          w_state_nxt     = ST_DONE;
          w_out_valid_nxt = 1'b1;
          w_req_nxt       = 1'b0;
          w_we_nxt        = 1'b0;
          w_addr_nxt      = 32'h0000_0000;
          w_wdata_nxt     = 32'h0000_0000;
          w_be_nxt        = 4'b0000;
          w_cnt_nxt       = {CNT_W{1'b0}};
          w_out_err_nxt   = ~dmem_ack;
          if (dmem_ack && r_is_load) begin
            w_mem_data_nxt = w_ext;
          end else begin
            w_mem_data_nxt = 32'h0000_0000;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_is_load   <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_be        <= 4'b0000;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_mem_data  <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_funct3    <= w_funct3_nxt;
      r_off       <= w_off_nxt;
      r_is_load   <= w_is_load_nxt;
      r_req       <= w_req_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_be        <= w_be_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_err   <= w_out_err_nxt;
      r_mem_data  <= w_mem_data_nxt;
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_err    = r_out_err;
  assign mem_data   = r_mem_data;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        out_valid;
  logic [31:0] mem_data;
  logic        out_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_vec;
  int n_err;

  mem_access_unit #(.DATA_W(32), .ACK_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .out_valid  (out_valid),
    .mem_data   (mem_data),
    .out_err    (out_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for exactly one accepting edge; returns in cycle 1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Ack during the current cycle; returns one cycle later.
  task automatic ack_now(input logic [31:0] rd);
    dmem_ack = 1'b1; dmem_rdata = rd;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got rdy=%b ov=%b err=%b, want 1 0 0", in_ready, out_valid, out_err);
    end
    n_vec++;
    if (mem_data !== 32'h0 || dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      n_err++; $display("FAIL reset_data: got md=%h req=%b we=%b, want 0 0 0", mem_data, dmem_req, dmem_we);
    end
    n_vec++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_be !== 4'h0) begin
      n_err++; $display("FAIL reset_bus: got a=%h wd=%h be=%b, want 0", dmem_addr, dmem_wdata, dmem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    n_vec++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b0000 || dmem_we !== 1'b0) begin
      n_err++; $display("FAIL lw_bus: got req=%b a=%h be=%b we=%b, want 1 00000100 0000 0", dmem_req, dmem_addr, dmem_be, dmem_we);
    end
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL lw_busy: got rdy=%b ov=%b, want 0 0", in_ready, out_valid);
    end
    next_cycle();
    ack_now(32'hDEAD_BEEF);
    n_vec++;
    if (out_valid !== 1'b1 || mem_data !== 32'hDEAD_BEEF || out_err !== 1'b0 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL lw_result: got ov=%b md=%h err=%b req=%b, want 1 deadbeef 0 0", out_valid, mem_data, out_err, dmem_req);
    end
    next_cycle();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL lw_hold: got ov=%b rdy=%b md=%h, want 0 1 deadbeef", out_valid, in_ready, mem_data);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [2];
    logic [31:0] as  [2];
    logic        sts [2];
    f3s[0] = 3'b010; as[0] = 32'h101; sts[0] = 1'b0;
    f3s[1] = 3'b001; as[1] = 32'h203; sts[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(~sts[i], sts[i], f3s[i], as[i], 32'hFFFF_FFFF);
      n_vec++;
      if (dmem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || mem_data !== 32'h0) begin
        n_err++; $display("FAIL misaligned[%0d]: got req=%b ov=%b err=%b md=%h, want 0 1 1 0", i, dmem_req, out_valid, out_err, mem_data);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [6];
    logic [31:0] as  [6];
    logic [31:0] exp [6];
    f3s[0] = 3'b000; as[0] = 32'h103; exp[0] = 32'hFFFF_FF80;
    f3s[1] = 3'b100; as[1] = 32'h103; exp[1] = 32'h0000_0080;
    f3s[2] = 3'b001; as[2] = 32'h102; exp[2] = 32'hFFFF_80FF;
    f3s[3] = 3'b101; as[3] = 32'h102; exp[3] = 32'h0000_80FF;
    f3s[4] = 3'b100; as[4] = 32'h100; exp[4] = 32'h0000_0000;
    f3s[5] = 3'b000; as[5] = 32'h102; exp[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, f3s[i], as[i], 32'h0);
      ack_now(32'h80FF_0000);
      n_vec++;
      if (out_valid !== 1'b1 || out_err !== 1'b0 || mem_data !== exp[i]) begin
        n_err++; $display("FAIL load_ext[%0d]: got ov=%b err=%b md=%h, want 1 0 %h", i, out_valid, out_err, mem_data, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_nonmem();
    issue(1'b0, 1'b0, 3'b010, 32'h101, 32'h0);
    n_vec++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b0 || mem_data !== 32'h0) begin
      n_err++; $display("FAIL nonmem: got req=%b ov=%b err=%b md=%h, want 0 1 0 0", dmem_req, out_valid, out_err, mem_data);
    end
    next_cycle();
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3];
    logic [31:0] as  [3];
    logic [31:0] ea  [3];
    logic [3:0]  ebe [3];
    logic [31:0] ewd [3];
    f3s[0] = 3'b000; as[0] = 32'h201; ea[0] = 32'h200; ebe[0] = 4'b0010; ewd[0] = 32'h7878_7878;
    f3s[1] = 3'b001; as[1] = 32'h202; ea[1] = 32'h200; ebe[1] = 4'b1100; ewd[1] = 32'h5678_5678;
    f3s[2] = 3'b010; as[2] = 32'h204; ea[2] = 32'h204; ebe[2] = 4'b1111; ewd[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, f3s[i], as[i], 32'h1234_5678);
      n_vec++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== ea[i] || dmem_be !== ebe[i] || dmem_wdata !== ewd[i]) begin
        n_err++; $display("FAIL store_bus[%0d]: got req=%b we=%b a=%h be=%b wd=%h, want 1 1 %h %b %h",
                          i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ea[i], ebe[i], ewd[i]);
      end
      ack_now(32'hCAFE_F00D);
      n_vec++;
      if (out_valid !== 1'b1 || out_err !== 1'b0 || mem_data !== 32'h0) begin
        n_err++; $display("FAIL store_result[%0d]: got ov=%b err=%b md=%h, want 1 0 0", i, out_valid, out_err, mem_data);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    int cyc;
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    req_cycles = 0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (dmem_req === 1'b1) req_cycles++;
      next_cycle();
      cyc++;
    end
    n_vec++;
    if (req_cycles != 16 || cyc != 17) begin
      n_err++; $display("FAIL timeout_len: got req_cycles=%0d out_valid_cycle=%0d, want 16 17", req_cycles, cyc);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || mem_data !== 32'h0 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL timeout_err: got ov=%b err=%b md=%h req=%b, want 1 1 0 0", out_valid, out_err, mem_data, dmem_req);
    end
    next_cycle();
    // Ack on the 16th request cycle must beat the timeout.
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    repeat (15) next_cycle();
    n_vec++;
    if (dmem_req !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL late_ack_req: got req=%b ov=%b, want 1 0", dmem_req, out_valid);
    end
    ack_now(32'h55AA_55AA);
    n_vec++;
    if (out_valid !== 1'b1 || out_err !== 1'b0 || mem_data !== 32'h55AA_55AA) begin
      n_err++; $display("FAIL late_ack_result: got ov=%b err=%b md=%h, want 1 0 55aa55aa", out_valid, out_err, mem_data);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_req();
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL async_reset: got req=%b rdy=%b, want 0 1", dmem_req, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    ack_now(32'h1111_1111);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_data !== 32'h0) begin
      n_err++; $display("FAIL stray_ack: got ov=%b rdy=%b md=%h, want 0 1 0", out_valid, in_ready, mem_data);
    end
    next_cycle();
    n_vec++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL stray_ack_after: got ov=%b req=%b, want 0 0", out_valid, dmem_req);
    end
  endtask

  // Hard stop in case the sequence never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_lw();
    test_misaligned();
    test_load_extend();
    test_nonmem();
    test_store();
    test_timeout();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine of the 32I core; the producer of the `mem_data` value consumed by write-back.
- Accepts one load/store per transaction from EX and drives a req/ack data-memory bus.
- Aligns, byte-enables and replicates store data.
- Extracts and sign/zero-extends load data and reports misalignment or bus timeout.
- Stalls the pipeline via `in_ready` while a transaction is outstanding.

Parameters:
- DATA_W, 32, data/address width (fixed at 32 for RV32I; no other value supported)
- ACK_TIMEOUT, 16, maximum cycles in REQ without `dmem_ack` before an error is reported (must be >= 1)

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX presents an operation
- in_ready  out  1  unit can accept; high only in IDLE
- is_load  in  1  operation is a load
- is_store  in  1  operation is a store (is_load & is_store both high is illegal: treated as load)
- funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value
- out_valid  out  1  one-cycle pulse: result ready for WB
- mem_data  out  32  extended load result (0 for stores, non-memory ops and errors)
- out_err  out  1  qualified by out_valid: misaligned access or bus timeout
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (all 0 on reads)
- dmem_ack  in  1  bus completes this cycle; rdata valid with it
- dmem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1. out_valid=0, out_err=0, mem_data=0. All dmem_* outputs = 0. Timeout counter = 0. A transaction in flight is abandoned; an ack arriving after reset release is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE & in_valid: register the operation, then:
  - neither load nor store -> DONE, out_err=0, mem_data=0.
  - misaligned (H with addr[0]=1, W with addr[1:0]!=0, or illegal funct3) -> DONE, out_err=1, no bus request.
  - otherwise -> REQ.
- REQ:
  - dmem_req=1, with stable addr/we/be/wdata until ack.
  - dmem_ack -> capture and extend rdata -> DONE.
  - Counter increments each REQ cycle without ack. On reaching ACK_TIMEOUT: drop req, -> DONE with out_err=1.
  - Ack on the same cycle the count reaches the limit wins: no error.
- DONE: out_valid=1 for exactly one cycle -> IDLE. mem_data/out_err are held until the next DONE.
- Latency (in_valid accepted at cycle 0):
  - req asserted cycle 1.
  - Ack at cycle k (k>=1) -> out_valid at k+1.
  - Non-memory op or error -> out_valid at cycle 1.
- Store lane rules (o = addr[1:0]):
  - SB: be = 1<<o, wdata = byte replicated x4.
  - SH: be = 0011 (o=0) or 1100 (o=2), wdata = halfword replicated x2.
  - SW: be = 1111.
- Load extraction: byte lane o, or halfword lane o[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- dmem_ack outside REQ is ignored.
- in_valid outside IDLE is ignored; EX must hold it while in_ready=0.

Decomposition:
- Shared core package: funct3 width-code constants, state encoding, bus byte-enable width.
- One natural sub-module, `load_extend`: combinational rdata/offset/funct3 -> 32-bit extended value. Reused for any future sub-word path.

Test Plan:
- LW at addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF -> dmem_addr=0x100, be=0000, out_valid at cycle 3, mem_data=0xDEADBEEF, out_err=0.
- LB/LBU at addr 0x103, rdata 0x80FF_0000:
  - LB -> mem_data=0xFFFFFF80.
  - LBU -> mem_data=0x00000080.
  - LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201, data 0x12345678 -> dmem_addr=0x200, be=0010, wdata=0x78787878, we=1. SH at 0x202 -> be=1100, wdata=0x56785678.
- LW at 0x101 -> no dmem_req, out_valid at cycle 1, out_err=1, mem_data=0.
- Load with ack never returned, ACK_TIMEOUT=16 -> req high for 16 cycles then low, out_valid with out_err=1. Repeat with ack on cycle 16 -> out_err=0.
- Assert rst_n=0 mid-REQ -> dmem_req drops without waiting for clk, in_ready=1. A later stray ack produces no out_valid.
